// File: rtl/pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_sequencer
// Brief    : Brings up and supervises the system PLL. Holds the PLL in reset,
//            waits for lock with timeout and bounded retries, requires a run
//            of stable lock before releasing the downstream synchronous reset,
//            and re-runs the sequence on loss of lock.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES     = 100,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [7:0] lol_count
);

  // The shared counter only has to reach (largest interval - 1).
  localparam int c_max_ht  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                             RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int c_max_all = (c_max_ht > LOCK_STABLE_CYCLES) ?
                             c_max_ht : LOCK_STABLE_CYCLES;
  localparam int c_cnt_w   = (c_max_all > 1) ? $clog2(c_max_all) : 1;

  localparam logic [c_cnt_w-1:0] c_hold_last    = c_cnt_w'(RST_HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one      = c_cnt_w'(1);
  localparam logic [3:0]         c_retry_max    = 4'(MAX_RETRIES);

  localparam logic [2:0] c_hold   = 3'd0;
  localparam logic [2:0] c_wait   = 3'd1;
  localparam logic [2:0] c_stable = 3'd2;
  localparam logic [2:0] c_run    = 3'd3;
  localparam logic [2:0] c_fault  = 3'd4;

  logic               r_sync1;
  logic               r_lock_s;
  logic [2:0]         r_state;
  logic [c_cnt_w-1:0] r_cnt;

  logic [2:0]         w_state_next;
  logic               w_cnt_clr;
  logic               w_retry_inc;
  logic               w_retry_clr;
  logic               w_lol_inc;
  logic               w_pll_rst;
  logic               w_sys_rst;
  logic               w_ready;
  logic               w_fault;

  // Two-flop synchronizer bringing the asynchronous PLL lock into refclk.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_lock_s <= 1'b0;
    end else begin
      r_sync1  <= pll_locked;
      r_lock_s <= r_sync1;
    end
  end

  // State register and shared interval counter (cleared on every state change).
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state <= c_hold;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state == c_hold || r_state == c_wait || r_state == c_stable) begin
        r_cnt <= r_cnt + c_cnt_one;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Next-state logic; restart overrides every other transition.
  always_comb begin
    w_state_next = r_state;
    w_retry_inc  = 1'b0;
    w_retry_clr  = 1'b0;
    w_lol_inc    = 1'b0;
    if (restart) begin
      w_state_next = c_hold;
      w_retry_clr  = 1'b1;
    end else begin
      case (r_state)
        c_hold: begin
          if (r_cnt == c_hold_last) w_state_next = c_wait;
        end
        c_wait: begin
          // A lock arriving on the timeout cycle still wins.
          if (r_lock_s) begin
            w_state_next = c_stable;
          end else if (r_cnt == c_timeout_last) begin
            if (retry_count == c_retry_max) begin
              w_state_next = c_fault;
            end else begin
              w_state_next = c_hold;
              w_retry_inc  = 1'b1;
            end
          end
        end
        c_stable: begin
          if (!r_lock_s) begin
            w_state_next = c_wait;
          end else if (r_cnt == c_stable_last) begin
            w_state_next = c_run;
            w_retry_clr  = 1'b1;
          end
        end
        c_run: begin
          if (!r_lock_s) begin
            w_state_next = c_hold;
            w_lol_inc    = 1'b1;
          end
        end
        c_fault: begin
          w_state_next = c_fault;
        end
        default: begin
          w_state_next = c_hold;
        end
      endcase
    end
  end

  assign w_cnt_clr = restart || (w_state_next != r_state);

  // Moore output decode of the upcoming state, so registered outputs track the state register.
  always_comb begin
    w_pll_rst = 1'b1;
    w_sys_rst = 1'b1;
    w_ready   = 1'b0;
    w_fault   = 1'b0;
    case (w_state_next)
      c_hold: begin
        w_pll_rst = 1'b1;
      end
      c_wait, c_stable: begin
        w_pll_rst = 1'b0;
      end
      c_run: begin
        w_pll_rst = 1'b0;
        w_sys_rst = 1'b0;
        w_ready   = 1'b1;
      end
      c_fault: begin
        w_fault = 1'b1;
      end
      default: begin
        w_pll_rst = 1'b1;
      end
    endcase
  end

  // Registered outputs and the retry / loss-of-lock bookkeeping.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
      retry_count <= 4'd0;
      lol_count   <= 8'd0;
    end else begin
      pll_rst <= w_pll_rst;
      sys_rst <= w_sys_rst;
      ready   <= w_ready;
      fault   <= w_fault;
      if (w_retry_clr) begin
        retry_count <= 4'd0;
      end else if (w_retry_inc) begin
        retry_count <= retry_count + 4'd1;
      end
      if (w_lol_inc && lol_count != 8'hFF) begin
        lol_count <= lol_count + 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_reset_sequencer
// Brief    : Self-checking bench for pll_reset_sequencer. A reference model
//            based on time-since-entry arithmetic predicts every cycle's
//            outputs into a queue; a monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_reset_sequencer;

  localparam int H = 4;
  localparam int T = 20;
  localparam int S = 8;
  localparam int R = 2;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [3:0] retry_count;
  logic [7:0] lol_count;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (H),
    .LOCK_TIMEOUT_CYCLES(T),
    .LOCK_STABLE_CYCLES (S),
    .MAX_RETRIES        (R)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fault      (fault),
    .retry_count(retry_count),
    .lol_count  (lol_count)
  );

  always #5 refclk = ~refclk;

  typedef enum int {P_HOLD, P_WAIT, P_STABLE, P_RUN, P_FAULT} phase_t;

  phase_t      m_phase;
  int          m_te;
  int          m_retry;
  int          m_lol;
  logic        m_p1;
  logic        m_p2;
  int          t;
  logic [15:0] exp_q[$];
  int          edge_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [15:0] model_outputs();
    logic pr, sr, rd, ft;
    pr = 1'b1; sr = 1'b1; rd = 1'b0; ft = 1'b0;
    case (m_phase)
      P_WAIT, P_STABLE: pr = 1'b0;
      P_RUN:   begin pr = 1'b0; sr = 1'b0; rd = 1'b1; end
      P_FAULT: ft = 1'b1;
      default: pr = 1'b1;
    endcase
    return {pr, sr, rd, ft, 4'(m_retry), 8'(m_lol)};
  endfunction

  task automatic model_reset();
    m_phase = P_HOLD;
    m_te    = t;
    m_retry = 0;
    m_lol   = 0;
    m_p1    = 1'b0;
    m_p2    = 1'b0;
  endtask

  // The FSM sees pll_locked two edges late; dwell times are measured as edges since entry.
  task automatic model_step(input logic lk, input logic rs);
    logic ls;
    int   el;
    ls   = m_p2;
    m_p2 = m_p1;
    m_p1 = lk;
    el   = t - m_te;
    if (rs) begin
      m_phase = P_HOLD; m_te = t; m_retry = 0;
    end else begin
      case (m_phase)
        P_HOLD:   if (el == H) begin m_phase = P_WAIT; m_te = t; end
        P_WAIT: begin
          if (ls) begin
            m_phase = P_STABLE; m_te = t;
          end else if (el == T) begin
            if (m_retry == R) begin m_phase = P_FAULT; m_te = t; end
            else begin m_retry++; m_phase = P_HOLD; m_te = t; end
          end
        end
        P_STABLE: begin
          if (!ls) begin m_phase = P_WAIT; m_te = t; end
          else if (el == S) begin m_phase = P_RUN; m_te = t; m_retry = 0; end
        end
        P_RUN: if (!ls) begin
          m_phase = P_HOLD; m_te = t;
          if (m_lol < 255) m_lol++;
        end
        default: m_phase = P_FAULT;
      endcase
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0d, expected %0d", nm, t, act, exp);
  endtask

  // Called at a falling edge: drive one cycle of stimulus and queue its prediction.
  task automatic step(input logic lk, input logic rs);
    pll_locked = lk;
    restart    = rs;
    t++;
    model_step(lk, rs);
    exp_q.push_back(model_outputs());
    edge_q.push_back(t);
    @(negedge refclk);
  endtask

  task automatic run_until(input phase_t tgt, input int bound);
    int k;
    k = 0;
    while (m_phase != tgt && k < bound) begin
      step(1'b1, 1'b0);
      k++;
    end
    if (m_phase != tgt) begin
      n_checks++;
      $display("FAIL bound waiting for phase %0d: reached %0d after %0d cycles", tgt, m_phase, k);
    end
  endtask

  task automatic async_reset_check();
    logic [15:0] act;
    #2 rst = 1'b1;
    #1;
    act = {pll_rst, sys_rst, ready, fault, retry_count, lol_count};
    n_checks++;
    if (act === 16'hC000) n_pass++;
    else $display("FAIL async_reset: got %h, expected c000", act);
    chk("lol_after_reset", int'(lol_count), 0);
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    model_reset();
  endtask

  // Monitor: compares DUT outputs just after each rising edge against the queued prediction.
  initial begin
    logic [15:0] exp, act;
    int          e;
    forever begin
      @(posedge refclk);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        e   = edge_q.pop_front();
        act = {pll_rst, sys_rst, ready, fault, retry_count, lol_count};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL outputs at edge %0d: got pll_rst=%b sys_rst=%b ready=%b fault=%b retry=%0d lol=%0d, expected %b %b %b %b %0d %0d",
                      e, act[15], act[14], act[13], act[12], act[11:8], act[7:0],
                      exp[15], exp[14], exp[13], exp[12], exp[11:8], exp[7:0]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first_hi, rdy_edge, g, lvl;
    logic [15:0] act;
    t          = 0;
    rst        = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;
    #2 rst = 1'b1;
    #1;
    act = {pll_rst, sys_rst, ready, fault, retry_count, lol_count};
    n_checks++;
    if (act === 16'hC000) n_pass++;
    else $display("FAIL reset_values: got %h, expected c000", act);
    @(negedge refclk);
    @(negedge refclk);
    rst = 1'b0;
    model_reset();

    // Clean bring-up: lock rises 5 cycles after pll_rst falls.
    repeat (3) step(1'b0, 1'b0);
    chk("pll_rst_held", int'(pll_rst), 1);
    step(1'b0, 1'b0);
    chk("pll_rst_fell", int'(pll_rst), 0);
    repeat (5) step(1'b0, 1'b0);
    first_hi = t + 1;
    rdy_edge = -1;
    repeat (12) begin
      step(1'b1, 1'b0);
      if (ready && rdy_edge < 0) rdy_edge = t;
    end
    chk("bringup_latency", rdy_edge - first_hi, 10);
    chk("bringup_sys_rst", int'(sys_rst), 0);
    chk("bringup_retry", int'(retry_count), 0);

    // Lock glitch during STABLE.
    step(1'b1, 1'b1);
    run_until(P_STABLE, 50);
    repeat ($urandom_range(1, 6)) step(1'b1, 1'b0);
    g = t + 1;
    step(1'b0, 1'b0);
    rdy_edge = -1;
    repeat (14) begin
      step(1'b1, 1'b0);
      if (ready && rdy_edge < 0) rdy_edge = t;
    end
    chk("glitch_latency", rdy_edge - g, 11);
    chk("glitch_retry", int'(retry_count), 0);

    // Repeated loss of lock in RUN until lol_count saturates.
    run_until(P_RUN, 50);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b0);
      step(1'($urandom_range(0, 1)), 1'b0);
      if (i == 0) chk("lol_still_ready", int'(ready), 1);
      step(1'($urandom_range(0, 1)), 1'b0);
      if (i == 0) begin
        chk("lol_sys_rst", int'(sys_rst), 1);
        chk("lol_ready", int'(ready), 0);
        chk("lol_count_1", int'(lol_count), 1);
      end
      run_until(P_RUN, 100);
      step(1'b1, 1'b0);
    end
    chk("lol_saturated", int'(lol_count), 255);

    // Asynchronous reset in the middle of STABLE.
    step(1'b1, 1'b1);
    run_until(P_STABLE, 50);
    repeat (2) step(1'b1, 1'b0);
    async_reset_check();

    // No lock at all: three attempts, then FAULT.
    for (int e = 1; e <= 72; e++) begin
      step(1'b0, 1'b0);
      if (e == 23 || e == 47) chk("nolock_pll_rst_low", int'(pll_rst), 0);
      if (e == 24 || e == 48) chk("nolock_pll_rst_pulse", int'(pll_rst), 1);
      if (e == 71) chk("nolock_no_fault_yet", int'(fault), 0);
    end
    chk("fault_set", int'(fault), 1);
    chk("fault_retry", int'(retry_count), 2);
    chk("fault_pll_rst", int'(pll_rst), 1);
    repeat (5) step(1'b0, 1'b0);
    chk("fault_terminal", int'(fault), 1);

    // Restart from FAULT, then restart colliding with a lock rise in WAIT_LOCK.
    step(1'b0, 1'b1);
    chk("restart_fault_clr", int'(fault), 0);
    chk("restart_retry_clr", int'(retry_count), 0);
    chk("restart_pll_rst", int'(pll_rst), 1);
    repeat (5) step(1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("restart_over_lock", int'(pll_rst), 1);

    // Randomized lock behaviour with occasional restarts.
    lvl = 1;
    repeat (1500) begin
      logic rs;
      if ($urandom_range(0, 11) == 0) lvl = 1 - lvl;
      rs = ($urandom_range(0, 99) == 0) && !(m_phase == P_RUN && m_p2 == 1'b0);
      step(1'(lvl), rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Sequences bring-up and supervision of the system PLL. It holds the PLL in reset for a fixed interval, waits for `locked` with a timeout and bounded retries, and requires lock to be continuously stable before releasing the design-wide synchronous reset. Loss of lock in service re-runs the whole sequence. It runs on the free-running board reference clock and sits between the PLL wrapper's `rst`/`locked` pins and the reset tree of the game logic.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 100: refclk cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 100000: cycles allowed in WAIT_LOCK before the attempt fails (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-lock cycles required before RUN (≥1).
- `MAX_RETRIES`, 3: retries after the first attempt before FAULT (0..15).

Ports:
- `refclk`, in, 1: single clock, 100 MHz, free-running. All logic is on this clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `pll_locked`, in, 1: PLL `locked`. It is asynchronous and passes through an internal 2-flop synchronizer to give `lock_s`.
- `restart`, in, 1: synchronous single-cycle soft restart request.
- `pll_rst`, out, 1: drives the PLL `rst`.
- `sys_rst`, out, 1: active-high reset for downstream logic.
- `ready`, out, 1: high only in RUN.
- `fault`, out, 1: high only in FAULT.
- `retry_count`, out, 4: retries consumed in the current bring-up.
- `lol_count`, out, 8: loss-of-lock events seen in RUN; saturates at 255.

## Operation
- FSM states: HOLD, WAIT_LOCK, STABLE, RUN, FAULT.
- One shared cycle counter, sized `$clog2` of the largest parameter. It clears on every state change.
- All outputs are registered Moore decodes of the state register:
  - HOLD: `pll_rst`=1, `sys_rst`=1.
  - WAIT_LOCK / STABLE: `pll_rst`=0, `sys_rst`=1.
  - RUN: `pll_rst`=0, `sys_rst`=0, `ready`=1.
  - FAULT: `pll_rst`=1, `sys_rst`=1, `fault`=1.
- HOLD: count. When the counter reaches `RST_HOLD_CYCLES-1`, go to WAIT_LOCK.
- WAIT_LOCK:
  - `lock_s`=1: go to STABLE.
  - Otherwise, when the counter reaches `LOCK_TIMEOUT_CYCLES-1`: if `retry_count==MAX_RETRIES`, go to FAULT; else increment `retry_count` and go to HOLD.
- STABLE:
  - Counter increments while `lock_s`=1.
  - `lock_s`=1 at count `LOCK_STABLE_CYCLES-1`: go to RUN.
  - `lock_s`=0 on any cycle: go to WAIT_LOCK. The timeout restarts and `retry_count` is unchanged.
- RUN: `lock_s`=0 sends the FSM to HOLD and increments `lol_count` (saturating).
- Entry to RUN clears `retry_count`.
- FAULT is terminal. Only `rst` or `restart` leaves it.
- `restart`=1 in any state: go to HOLD and clear `retry_count` and the counter.
  - `restart` overrides every other transition in the same cycle.
  - `lol_count` is not cleared by `restart`.
- Simultaneous timeout and `lock_s` rise in WAIT_LOCK: lock wins and the FSM goes to STABLE.

## Timing
- Reset values (applied asynchronously, no clock needed):
  - state HOLD, counter 0.
  - `pll_rst`=1, `sys_rst`=1, `ready`=0, `fault`=0.
  - `retry_count`=0, `lol_count`=0.
- `pll_rst` falls at the `RST_HOLD_CYCLES`-th rising edge after `rst` deasserts.
- Lock input latency, with `pll_locked` first sampled high at edge N:
  - `lock_s`=1 after edge N+1.
  - State STABLE after edge N+2.
  - RUN, `ready`=1 and `sys_rst`=0 after edge N+2+`LOCK_STABLE_CYCLES`.
- Loss of lock, with `pll_locked` first sampled low at edge N: state HOLD, `sys_rst`=1, `ready`=0 after edge N+2.
- `restart` sampled at edge N: new state and outputs are visible after edge N.
- One failed attempt lasts `RST_HOLD_CYCLES+LOCK_TIMEOUT_CYCLES` cycles.
- FAULT is reached `(MAX_RETRIES+1)` attempts after reset.

## Test plan
Bench parameters: `RST_HOLD_CYCLES`=4, `LOCK_TIMEOUT_CYCLES`=20, `LOCK_STABLE_CYCLES`=8, `MAX_RETRIES`=2.
- Clean bring-up: release `rst`; raise `pll_locked` 5 cycles after `pll_rst` falls.
  - `pll_rst` is high exactly 4 edges.
  - `ready`=1 and `sys_rst`=0 exactly 10 edges after the first high sample.
  - `retry_count`=0.
- Lock glitch: drop `pll_locked` for 1 cycle after 4 STABLE cycles.
  - FSM returns to WAIT_LOCK.
  - `ready` rises only after 8 further consecutive `lock_s` cycles.
  - `retry_count` stays 0.
- No lock: hold `pll_locked`=0.
  - Three 24-cycle attempts run; `pll_rst` pulses at edges 0, 24 and 48.
  - `fault`=1 after edge 72, with `retry_count`=2 and `pll_rst`=1 held.
- Loss of lock in RUN: drop `pll_locked`.
  - `sys_rst`=1 and `ready`=0 after 2 edges; `lol_count`=1.
  - Re-lock reaches RUN again.
  - Repeat 300 times: `lol_count` saturates at 255.
- Restart from FAULT: pulse `restart`.
  - `fault`=0, state HOLD and `retry_count`=0 after that edge.
  - `restart` together with `lock_s` rise in WAIT_LOCK also goes to HOLD.
- Asynchronous reset mid-STABLE: assert `rst` between clock edges.
  - All outputs take their reset values immediately with no clock edge.
  - `lol_count`=0.
